hilo_divu_unit: RTL

//  Multi-cycle unsigned divider with the architectural HI/LO registers for the MIPS CPU.

---
 rtl/mips_pkg.sv | 19 +
 rtl/divu_step.sv | 34 +++
 rtl/hilo_divu_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg: shared MIPS decode constants and divider state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [5:0] FUNCT_DIVU = 6'd27;
  localparam logic [5:0] FUNCT_MFHI = 6'd16;
  localparam logic [5:0] FUNCT_MFLO = 6'd18;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/divu_step.sv
// ============================================================================
// divu_step: one combinational restoring-division iteration.
// Revision: 1.0
// ============================================================================
`default_nettype none

module divu_step
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // Shifted partial remainder keeps its carry-out bit so divisors above
  // 2^(WIDTH-1) still compare correctly.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign fits    = (shifted >= {1'b0, dvs});

  assign rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

`default_nettype wire

// File: rtl/hilo_divu_unit.sv
// ============================================================================
// hilo_divu_unit: multi-cycle unsigned divider owning the HI/LO registers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hilo_divu_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mf_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             accept;

  divu_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .dvs      (dvs),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign busy   = (state == ST_CALC);
  assign done   = (state == ST_DONE);
  assign stall  = busy & (mf_req | start);
  assign accept = start & (state != ST_CALC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      count <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (accept) begin
      rem   <= '0;
      quo   <= dividend;
      dvs   <= divisor;
      count <= '0;
      if (divisor == '0) begin
        hi    <= dividend;
        lo    <= '1;
        state <= ST_DONE;
      end else begin
        state <= ST_CALC;
      end
    end else begin
      case (state)
        ST_CALC: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + 1'b1;
          // HI/LO only change on the final iteration.
          if (count == LAST_COUNT) begin
            hi    <= rem_next;
            lo    <= quo_next;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
